// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared encodings for the iterative multiply/divide unit.
//   - OP_*  : 2-bit operation codes presented on muldiv_unit.op
//   - ST_*  : FSM state codes (IDLE -> BUSY -> DONE -> IDLE)
package muldiv_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/muldiv_div_step.sv
// div_step
//   One combinational restoring-division step.
//   Ports:
//     rem_in   [WIDTH:0]   partial remainder from the previous step
//     bit_in               next dividend bit shifted into the remainder
//     divisor  [WIDTH-1:0] divisor
//     rem_out  [WIDTH:0]   partial remainder after this step (never negative)
//     q_bit                quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Subtract on a two-bit-wider copy so the borrow lands in the top bit;
  // a borrow means the trial subtraction is undone (restoring step).
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, divisor};
    if (diff[WIDTH+1]) begin
      rem_out = shifted[WIDTH:0];
      q_bit   = 1'b0;
    end else begin
      rem_out = diff[WIDTH:0];
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative unsigned multiply/divide unit beside the Execute-stage ALU.
//   One shift-add (multiply) or restoring subtract-shift (divide) per cycle.
//   Ports:
//     clock, reset_n          rising-edge clock, async active-low reset
//     start                   level request from the instruction in Execute
//     op [1:0]                OP_MUL / OP_MULHU / OP_DIVU / OP_REMU
//     operand_a, operand_b    multiplicand/dividend, multiplier/divisor
//     kill                    Execute flush, aborts the in-flight op
//     alu_ready               low stalls Fetch/Decode/Execute
//     busy                    high while iterating
//     result [WIDTH-1:0]      registered result of the last completed op
//   Configuration:
//     MULDIV_EARLY_EXIT_EN    multiply finishes as soon as the remaining
//                             multiplier bits are all zero
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             kill,
  output logic             alu_ready,
  output logic             busy,
  output logic [WIDTH-1:0] result
);

  logic [1:0]         state;
  logic [1:0]         op_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   result_q;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_rem;
  logic               div_q;
  logic [2*WIDTH-1:0] prod_final;
  logic [WIDTH-1:0]   result_sel;
  logic               mul_exit;

  assign alu_ready = ((state == ST_IDLE) && !start) || (state == ST_DONE);
  assign busy      = (state == ST_BUSY);
  assign result    = result_q;
  assign cnt_next  = cnt - 1'b1;

  // acc holds {partial product, unshifted multiplier} for multiplies and
  // {unused, dividend-becoming-quotient} for divides. mcand_q holds the
  // multiplicand or the divisor.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem_q),
    .bit_in  (acc[WIDTH-1]),
    .divisor (mcand_q),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

`ifdef MULDIV_EARLY_EXIT_EN
  logic [WIDTH-1:0] rem_mask;

  // After k steps acc is (partial product << remaining) with the remaining
  // multiplier bits below it; once those are zero the product is complete
  // and only needs shifting down by the remaining count.
  always_comb begin
    rem_mask   = ~({WIDTH{1'b1}} << cnt_next);
    mul_exit   = ((mul_next[WIDTH-1:0] & rem_mask) == {WIDTH{1'b0}});
    prod_final = acc >> cnt;
  end
`else
  always_comb begin
    mul_exit   = 1'b0;
    prod_final = acc;
  end
`endif

  always_comb begin
    case (op_q)
      OP_MUL:   result_sel = prod_final[WIDTH-1:0];
      OP_MULHU: result_sel = prod_final[2*WIDTH-1:WIDTH];
      OP_DIVU:  result_sel = acc[WIDTH-1:0];
      default:  result_sel = rem_q[WIDTH-1:0];
    endcase
  end

  // Main FSM and datapath. kill wins over everything, including start.
  // Divide by zero skips BUSY and preloads the architected answers
  // (all-ones quotient, dividend as remainder).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_MUL;
      cnt      <= '0;
      mcand_q  <= '0;
      acc      <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else if (kill) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op;
            rem_q <= '0;
            if (op[1]) begin
              mcand_q <= operand_b;
              if (operand_b == '0) begin
                acc   <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                rem_q <= {1'b0, operand_a};
                cnt   <= '0;
                state <= ST_DONE;
              end else begin
                acc   <= {{WIDTH{1'b0}}, operand_a};
                cnt   <= CNT_W'(WIDTH);
                state <= ST_BUSY;
              end
            end else begin
              mcand_q <= operand_a;
              acc     <= {{WIDTH{1'b0}}, operand_b};
              cnt     <= CNT_W'(WIDTH);
              state   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (op_q[1]) begin
            acc   <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_q};
            rem_q <= div_rem;
          end else begin
            acc <= mul_next;
          end
          cnt <= cnt_next;
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
          end else if (!op_q[1] && mul_exit) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          result_q <= result_sel;
          cnt      <= '0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
